// File: rtl/inst_buffer_nway_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_nway_pkg
// Brief    : Shared defaults for the per-warp instruction buffer.
//            Optional feature macro: INSTBUF_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package inst_buffer_nway_pkg;

    // Default sizing of the FastLanes SM instruction buffer.
    localparam int C_NUM_WARP_DEF     = 4;
    localparam int C_NUM_WARP_LOG_DEF = 2;
    localparam int C_DEPTH_DEF        = 4;
    localparam int C_DEPTH_LOG_DEF    = 2;
    localparam int C_PKT_W_DEF        = 182;

    // Arbiter pointer value after reset.
    // This setting makes the first round-robin search start at warp 0.
    function automatic int prewarp_start(input int num_warp);
        return num_warp - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_buffer_nway_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_nway_rr_arbiter
// Brief    : Combinational round-robin warp arbiter. Search starts at
//            preWarp+1, wraps, and the first ready warp wins.
// Revision : 1.0 - initial release
// ============================================================================
module inst_buffer_nway_rr_arbiter
    import inst_buffer_nway_pkg::*;
#(
    parameter int NUM_WARP     = C_NUM_WARP_DEF,
    parameter int NUM_WARP_LOG = C_NUM_WARP_LOG_DEF
)(
    input  logic [NUM_WARP_LOG-1:0] preWarp,
    input  logic [NUM_WARP-1:0]     readyVector,
    output logic [NUM_WARP_LOG-1:0] grantWarp,
    output logic                    anyGrant
);

    // Walk the candidates farthest-first, so the nearest ready warp after preWarp
    // makes the last assignment and wins.
    always_comb begin
        logic [NUM_WARP_LOG-1:0] w_idx;
        w_idx     = '0;
        grantWarp = '0;
        anyGrant  = |readyVector;
        for (int i = NUM_WARP; i >= 1; i--) begin
            w_idx = preWarp + NUM_WARP_LOG'(i);
            if (readyVector[w_idx]) begin
                grantWarp = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_buffer_nway.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_nway
// Brief    : Per-warp in-order instruction queues between decode and select,
//            two-packet enqueue per cycle, round-robin single issue with
//            registered outputs, per-warp flush, global stall, sticky overflow.
//            Optional feature macro: INSTBUF_PERF_CNT_EN (issue/hazard counters).
// Revision : 1.0 - initial release
// ============================================================================
module inst_buffer_nway
    import inst_buffer_nway_pkg::*;
#(
    parameter int NUM_WARP     = C_NUM_WARP_DEF,
    parameter int NUM_WARP_LOG = C_NUM_WARP_LOG_DEF,
    parameter int DEPTH        = C_DEPTH_DEF,
    parameter int DEPTH_LOG    = C_DEPTH_LOG_DEF,
    parameter int PKT_W        = C_PKT_W_DEF
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WARP_LOG-1:0] decodedWarp_i,
    input  logic                    decodedPacket0Valid_i,
    input  logic                    decodedPacket1Valid_i,
    input  logic [PKT_W-1:0]        decodedPacket0_i,
    input  logic [PKT_W-1:0]        decodedPacket1_i,
    input  logic [NUM_WARP-1:0]     hazardVector_i,
    input  logic                    toSelectReady_i,
    input  logic                    flush_i,
    input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
    input  logic                    stall_i,
    output logic [NUM_WARP-1:0]     warpValidVector_o,
    output logic [NUM_WARP-1:0]     warpFullVector_o,
    output logic [NUM_WARP_LOG-1:0] selectedWarp_o,
    output logic                    selectedPacketValid_o,
    output logic [PKT_W-1:0]        selectedPacket_o,
    output logic                    overflowErr_o
`ifdef INSTBUF_PERF_CNT_EN
    ,
    output logic [31:0]             issueCount_o,
    output logic [31:0]             hazardStallCount_o
`endif
);

    localparam logic [DEPTH_LOG:0]      C_DEPTH         = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]      C_TWO           = (DEPTH_LOG+1)'(2);
    localparam logic [NUM_WARP_LOG-1:0] C_PREWARP_START = NUM_WARP_LOG'(prewarp_start(NUM_WARP));

    logic [PKT_W-1:0]        r_mem    [NUM_WARP][DEPTH];
    logic [DEPTH_LOG-1:0]    r_rd_ptr [NUM_WARP];
    logic [DEPTH_LOG-1:0]    r_wr_ptr [NUM_WARP];
    logic [DEPTH_LOG:0]      r_count  [NUM_WARP];
    logic [NUM_WARP_LOG-1:0] r_pre_warp;
    logic                    r_overflow;
    logic                    r_sel_valid;
    logic [NUM_WARP_LOG-1:0] r_sel_warp;
    logic [PKT_W-1:0]        r_sel_pkt;

    logic [DEPTH_LOG:0]      w_free     [NUM_WARP];
    logic [DEPTH_LOG:0]      w_enq_cnt  [NUM_WARP];
    logic [NUM_WARP-1:0]     w_deq;
    logic [NUM_WARP-1:0]     w_flush_hit;
    logic [NUM_WARP-1:0]     w_ready;
    logic [NUM_WARP-1:0]     w_valid_vec;
    logic [NUM_WARP-1:0]     w_full_vec;
    logic [NUM_WARP_LOG-1:0] w_grant_warp;
    logic                    w_any_grant;
    logic                    w_flush_act;
    logic                    w_fire;
    logic                    w_enq_ok;
    logic [DEPTH_LOG:0]      w_dec_free;
    logic [DEPTH_LOG:0]      w_n_req;
    logic [DEPTH_LOG:0]      w_n_enq;
    logic                    w_ovf_evt;
    logic [PKT_W-1:0]        w_pkt_a;
    logic [DEPTH_LOG-1:0]    w_wr_a;
    logic [DEPTH_LOG-1:0]    w_wr_b;

    // Per-warp occupancy status derived from the registered counts.
    always_comb begin
        for (int w = 0; w < NUM_WARP; w++) begin
            w_free[w]      = C_DEPTH - r_count[w];
            w_valid_vec[w] = (r_count[w] != '0);
            w_full_vec[w]  = (w_free[w] < C_TWO);
            w_ready[w]     = w_valid_vec[w] & ~hazardVector_i[w];
        end
    end

    inst_buffer_nway_rr_arbiter #(
        .NUM_WARP     (NUM_WARP),
        .NUM_WARP_LOG (NUM_WARP_LOG)
    ) u_arb (
        .preWarp     (r_pre_warp),
        .readyVector (w_ready),
        .grantWarp   (w_grant_warp),
        .anyGrant    (w_any_grant)
    );

    // Grant and enqueue decisions. Free space uses the pre-cycle count, so a
    // same-cycle dequeue never makes room for an incoming packet.
    always_comb begin
        w_flush_act = flush_i & ~stall_i;
        w_fire      = w_any_grant & toSelectReady_i & ~stall_i &
                      ~(w_flush_act & (flushWarp_i == w_grant_warp));
        w_enq_ok    = ~stall_i & ~(w_flush_act & (flushWarp_i == decodedWarp_i));
        w_dec_free  = w_free[decodedWarp_i];
        w_n_req     = (DEPTH_LOG+1)'(decodedPacket0Valid_i) + (DEPTH_LOG+1)'(decodedPacket1Valid_i);
        w_n_enq     = '0;
        w_ovf_evt   = 1'b0;
        if (w_enq_ok) begin
            w_n_enq   = (w_n_req > w_dec_free) ? w_dec_free : w_n_req;
            w_ovf_evt = (w_n_req > w_dec_free);
        end
        // A lone packet1 still lands at the tail slot.
        w_pkt_a = decodedPacket0Valid_i ? decodedPacket0_i : decodedPacket1_i;
        w_wr_a  = r_wr_ptr[decodedWarp_i];
        w_wr_b  = w_wr_a + DEPTH_LOG'(1);
        for (int w = 0; w < NUM_WARP; w++) begin
            w_enq_cnt[w]   = (decodedWarp_i == NUM_WARP_LOG'(w)) ? w_n_enq : '0;
            w_deq[w]       = w_fire & (w_grant_warp == NUM_WARP_LOG'(w));
            w_flush_hit[w] = w_flush_act & (flushWarp_i == NUM_WARP_LOG'(w));
        end
    end

    // Packet storage: up to two writes per cycle into the decoded warp's queue.
    always_ff @(posedge clk) begin
        if (w_n_enq != '0) begin
            r_mem[decodedWarp_i][w_wr_a] <= w_pkt_a;
        end
        if (w_n_enq == C_TWO) begin
            r_mem[decodedWarp_i][w_wr_b] <= decodedPacket1_i;
        end
    end

    // Queue pointers and counts. A flush wins over any same-cycle activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                r_rd_ptr[w] <= '0;
                r_wr_ptr[w] <= '0;
                r_count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARP; w++) begin
                if (w_flush_hit[w]) begin
                    r_rd_ptr[w] <= '0;
                    r_wr_ptr[w] <= '0;
                    r_count[w]  <= '0;
                end else begin
                    r_wr_ptr[w] <= r_wr_ptr[w] + w_enq_cnt[w][DEPTH_LOG-1:0];
                    r_rd_ptr[w] <= r_rd_ptr[w] + DEPTH_LOG'(w_deq[w]);
                    r_count[w]  <= r_count[w] + w_enq_cnt[w] - (DEPTH_LOG+1)'(w_deq[w]);
                end
            end
        end
    end

    // Registered issue towards select; all outputs hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_valid <= 1'b0;
            r_sel_warp  <= '0;
            r_sel_pkt   <= '0;
            r_pre_warp  <= C_PREWARP_START;
        end else if (!stall_i) begin
            if (w_fire) begin
                r_sel_valid <= 1'b1;
                r_sel_warp  <= w_grant_warp;
                r_sel_pkt   <= r_mem[w_grant_warp][r_rd_ptr[w_grant_warp]];
                r_pre_warp  <= w_grant_warp;
            end else begin
                r_sel_valid <= 1'b0;
                r_sel_warp  <= '0;
                r_sel_pkt   <= '0;
            end
        end
    end

    // Sticky overflow: set whenever a packet is dropped for lack of space.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef INSTBUF_PERF_CNT_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_haz_cnt;

    // Issue and hazard-stall counters, frozen during global stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_cnt <= '0;
            r_haz_cnt   <= '0;
        end else if (!stall_i) begin
            if (w_fire) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if ((|w_valid_vec) && !(|w_ready)) begin
                r_haz_cnt <= r_haz_cnt + 32'd1;
            end
        end
    end

    assign issueCount_o       = r_issue_cnt;
    assign hazardStallCount_o = r_haz_cnt;
`else
    // Counters are not built in this configuration.
`endif

    assign warpValidVector_o     = w_valid_vec;
    assign warpFullVector_o      = w_full_vec;
    assign selectedWarp_o        = r_sel_warp;
    assign selectedPacketValid_o = r_sel_valid;
    assign selectedPacket_o      = r_sel_pkt;
    assign overflowErr_o         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_buffer_nway
// Brief    : Randomized self-checking bench for inst_buffer_nway against a
//            queue-based reference model.
//            Optional feature macro: INSTBUF_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_buffer_nway;

    localparam int NW  = 4;
    localparam int NWL = 2;
    localparam int D   = 4;
    localparam int DL  = 2;
    localparam int PW  = 182;

    typedef logic [PW-1:0] pkt_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [NWL-1:0] dec_warp;
    logic           v0, v1;
    pkt_t           p0, p1;
    logic [NW-1:0]  haz;
    logic           tsr;
    logic           fl;
    logic [NWL-1:0] fl_warp;
    logic           stall;
    logic [NW-1:0]  valid_vec, full_vec;
    logic [NWL-1:0] sel_warp;
    logic           sel_valid;
    pkt_t           sel_pkt;
    logic           ovf;
`ifdef INSTBUF_PERF_CNT_EN
    logic [31:0]    issue_cnt, haz_cnt;
`endif

    inst_buffer_nway #(
        .NUM_WARP(NW), .NUM_WARP_LOG(NWL), .DEPTH(D), .DEPTH_LOG(DL), .PKT_W(PW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .decodedWarp_i         (dec_warp),
        .decodedPacket0Valid_i (v0),
        .decodedPacket1Valid_i (v1),
        .decodedPacket0_i      (p0),
        .decodedPacket1_i      (p1),
        .hazardVector_i        (haz),
        .toSelectReady_i       (tsr),
        .flush_i               (fl),
        .flushWarp_i           (fl_warp),
        .stall_i               (stall),
        .warpValidVector_o     (valid_vec),
        .warpFullVector_o      (full_vec),
        .selectedWarp_o        (sel_warp),
        .selectedPacketValid_o (sel_valid),
        .selectedPacket_o      (sel_pkt),
        .overflowErr_o         (ovf)
`ifdef INSTBUF_PERF_CNT_EN
        ,
        .issueCount_o          (issue_cnt),
        .hazardStallCount_o    (haz_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    pkt_t mq [NW][$];
    int   m_pre;
    bit   m_ovf;
    bit   e_valid;
    int   e_warp;
    pkt_t e_pkt;
    int unsigned m_issue, m_haz;

    task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p = '0;
        for (int i = 0; i < 6; i++) p = {p[PW-33:0], 32'($urandom)};
        return p;
    endfunction

    // One cycle of the reference behaviour, evaluated on pre-edge state.
    task automatic model_step();
        int g;
        int free_slots;
        bit any_nonempty;
        if (stall) return;
        free_slots   = D - mq[dec_warp].size();
        g            = -1;
        any_nonempty = 0;
        for (int w = 0; w < NW; w++) if (mq[w].size() > 0) any_nonempty = 1;
        for (int k = 1; k <= NW; k++) begin
            int w = (m_pre + k) % NW;
            if (g < 0 && mq[w].size() > 0 && !haz[w]) g = w;
        end
        if (any_nonempty && g < 0) m_haz++;
        e_valid = 0; e_warp = 0; e_pkt = '0;
        if (g >= 0 && tsr && !(fl && int'(fl_warp) == g)) begin
            e_valid = 1;
            e_warp  = g;
            e_pkt   = mq[g].pop_front();
            m_pre   = g;
            m_issue++;
        end
        if (!(fl && fl_warp == dec_warp)) begin
            if (v0) begin
                if (free_slots > 0) begin mq[dec_warp].push_back(p0); free_slots--; end
                else m_ovf = 1;
            end
            if (v1) begin
                if (free_slots > 0) begin mq[dec_warp].push_back(p1); free_slots--; end
                else m_ovf = 1;
            end
        end
        if (fl) mq[fl_warp].delete();
    endtask

    task automatic check_all();
        logic [NW-1:0] ev, ef;
        for (int w = 0; w < NW; w++) begin
            ev[w] = (mq[w].size() != 0);
            ef[w] = ((D - mq[w].size()) < 2);
        end
        check_val("sel_valid", PW'(sel_valid), PW'(e_valid));
        check_val("sel_warp",  PW'(sel_warp),  PW'(e_warp));
        check_val("sel_pkt",   sel_pkt,        e_pkt);
        check_val("valid_vec", PW'(valid_vec), PW'(ev));
        check_val("full_vec",  PW'(full_vec),  PW'(ef));
        check_val("overflow",  PW'(ovf),       PW'(m_ovf));
`ifdef INSTBUF_PERF_CNT_EN
        check_val("issue_cnt", PW'(issue_cnt), PW'(m_issue));
        check_val("haz_cnt",   PW'(haz_cnt),   PW'(m_haz));
`endif
    endtask

    initial begin
        int enq_pct, haz_pct, tsr_pct, stall_pct, fl_pct;
        reset = 1'b1;
        dec_warp = '0; v0 = 0; v1 = 0; p0 = '0; p1 = '0;
        haz = '0; tsr = 0; fl = 0; fl_warp = '0; stall = 0;
        m_pre = NW - 1; m_ovf = 0; e_valid = 0; e_warp = 0; e_pkt = '0;
        m_issue = 0; m_haz = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();

        enq_pct = 50; haz_pct = 20; tsr_pct = 80; stall_pct = 10; fl_pct = 4;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) begin
                case ((cyc / 250) % 4)
                    0: begin enq_pct = 50; haz_pct = 20; tsr_pct = 85; stall_pct = 10; fl_pct = 3; end
                    1: begin enq_pct = 90; haz_pct = 40; tsr_pct = 50; stall_pct = 5;  fl_pct = 2; end
                    2: begin enq_pct = 30; haz_pct = 5;  tsr_pct = 100; stall_pct = 15; fl_pct = 6; end
                    default: begin enq_pct = 70; haz_pct = 60; tsr_pct = 70; stall_pct = 10; fl_pct = 4; end
                endcase
            end
            dec_warp = NWL'($urandom_range(0, NW-1));
            v0       = ($urandom_range(0, 99) < enq_pct);
            v1       = ($urandom_range(0, 99) < enq_pct);
            p0       = rand_pkt();
            p1       = rand_pkt();
            for (int w = 0; w < NW; w++) haz[w] = ($urandom_range(0, 99) < haz_pct);
            tsr      = ($urandom_range(0, 99) < tsr_pct);
            stall    = ($urandom_range(0, 99) < stall_pct);
            fl       = ($urandom_range(0, 99) < fl_pct);
            fl_warp  = NWL'($urandom_range(0, NW-1));
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
